rx_packer: RTL

Receive-side channel adapter: terminates one RIFFA-style PCIe RX channel transaction, accepts its 32-bit words and packs them into WIDTH-bit instructions. Presents them on a valid/ready stream that feeds the instruction FIFO directly (`o_val`/`o_rdy`/`o_data` connect to its `i_val`/`i_rdy`/`i_data`). One word per cycle sustained when the FIFO is not full.

---
 rtl/rx_packer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rx_packer.sv
// Packs 32-bit words from a RIFFA-style RX channel into WIDTH-bit instruction beats.
// Define RX_PAD_EN to zero-fill and emit a trailing partial beat; otherwise it is dropped.
module rx_packer #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             CHNL_RX,
   output logic             CHNL_RX_ACK,
   input  logic             CHNL_RX_LAST,
   input  logic [31:0]      CHNL_RX_LEN,
   input  logic [30:0]      CHNL_RX_OFF,
   input  logic [31:0]      CHNL_RX_DATA,
   input  logic             CHNL_RX_DATA_VALID,
   output logic             CHNL_RX_DATA_REN,
   output logic             o_val,
   input  logic             o_rdy,
   output logic [WIDTH-1:0] o_data,
   output logic             o_err
);

   localparam int unsigned Pieces = WIDTH / 32;
   localparam int unsigned IdxW   = (Pieces > 1) ? $clog2(Pieces) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(Pieces - 1);

   typedef enum logic [1:0] {StIdle, StAck, StRecv, StWaitLow} state_e;

   state_e           state_q, state_d;
   logic [31:0]      remain_q, remain_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] pack_q, pack_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             val_q, val_d;
   logic             err_q, err_d;
   logic             accept;

   logic unused_inputs;
   assign unused_inputs = ^{CHNL_RX_LAST, CHNL_RX_OFF};

`ifdef RX_PAD_EN
   logic out_free;
   assign out_free = !val_q || o_rdy;

   // Slots at or above n were never written for this beat; force them to zero.
   function automatic logic [WIDTH-1:0] pad_tail(input logic [WIDTH-1:0] w,
                                                 input logic [IdxW-1:0] n);
      logic [WIDTH-1:0] r;
      r = w;
      for (int k = 0; k < int'(Pieces); k++) begin
         if (k >= int'(n)) r[32*k +: 32] = '0;
      end
      return r;
   endfunction
`endif

   assign CHNL_RX_ACK      = (state_q == StAck);
   assign CHNL_RX_DATA_REN = (state_q == StRecv) && (remain_q != '0) &&
                             ((idx_q != LastIdx) || !val_q || o_rdy);
   assign accept           = CHNL_RX_DATA_REN && CHNL_RX_DATA_VALID;
   assign o_val            = val_q;
   assign o_data           = out_q;
   assign o_err            = err_q;

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      idx_d    = idx_q;
      pack_d   = pack_q;
      out_d    = out_q;
      val_d    = val_q && !o_rdy;
      err_d    = err_q;
      unique case (state_q)
         StIdle: begin
            if (CHNL_RX) begin
               remain_d = CHNL_RX_LEN;
               idx_d    = '0;
               state_d  = StAck;
            end
         end
         StAck: state_d = (remain_q == '0) ? StWaitLow : StRecv;
         StRecv: begin
            if (accept) begin
               pack_d[32*int'(idx_q) +: 32] = CHNL_RX_DATA;
               remain_d = remain_q - 32'd1;
               if (idx_q == LastIdx) begin
                  idx_d = '0;
                  out_d = pack_d;
                  val_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            if (remain_q == '0) begin
               if (idx_q == '0) begin
                  state_d = StWaitLow;
               end else begin
`ifdef RX_PAD_EN
                  if (out_free) begin
                     out_d   = pad_tail(pack_q, idx_q);
                     val_d   = 1'b1;
                     idx_d   = '0;
                     state_d = StWaitLow;
                  end
`else
                  err_d   = 1'b1;
                  idx_d   = '0;
                  state_d = StWaitLow;
`endif
               end
            end else if (!CHNL_RX) begin
               err_d = 1'b1;
               if (idx_d == '0) begin
                  state_d = StIdle;
               end else begin
`ifdef RX_PAD_EN
                  // Output busy: zero remain so the normal tail path flushes it later.
                  if (out_free) begin
                     out_d   = pad_tail(pack_d, idx_d);
                     val_d   = 1'b1;
                     idx_d   = '0;
                     state_d = StIdle;
                  end else begin
                     remain_d = '0;
                  end
`else
                  idx_d   = '0;
                  state_d = StIdle;
`endif
               end
            end
         end
         StWaitLow: if (!CHNL_RX) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         remain_q <= '0;
         idx_q    <= '0;
         pack_q   <= '0;
         out_q    <= '0;
         val_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         idx_q    <= idx_d;
         pack_q   <= pack_d;
         out_q    <= out_d;
         val_q    <= val_d;
         err_q    <= err_d;
      end
   end

endmodule
